// File: rtl/hrm_mem_arbiter.sv
// ---------------------------------------------------------------------------
// hrm_mem_arbiter
// Shares the single-port data RAM between the CPU datapath (port 0) and the
// debug/loader port (port 1). Each port performs one req/ack transaction; the
// arbiter picks a winner, drives exactly one RAM access and returns read data.
//
// Parameters
//   AW        RAM address width
//   DW        RAM data width
//   RD_LAT    RAM read latency in cycles after the issue cycle (1..3)
//   PRIORITY  0 = round-robin on ties, 1 = port 0 always wins ties
//
// Ports
//   clk, i_rst_n                      clock (rising edge), async active-low reset
//   req0/we0/addr0/wdata0             port 0 request (level, held until ack0)
//   ack0, rdata0                      port 0 one-cycle done pulse, read data
//   req1/we1/addr1/wdata1/ack1/rdata1 port 1, same as port 0
//   ram_en/ram_we/ram_addr/ram_wdata  registered RAM command
//   ram_rdata                         RAM read data
//   gnt                               one-hot owner from ISSUE through ACK
//   busy                              high whenever the arbiter is not IDLE
// ---------------------------------------------------------------------------
module hrm_mem_arbiter #(
    parameter int AW       = 8,
    parameter int DW       = 8,
    parameter int RD_LAT   = 1,
    parameter int PRIORITY = 0
) (
    input  logic          clk,
    input  logic          i_rst_n,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          ack0,
    output logic [DW-1:0] rdata0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          ack1,
    output logic [DW-1:0] rdata1,
    output logic          ram_en,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata,
    output logic [1:0]    gnt,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        ACK   = 2'd3
    } state_t;

    // The WAIT counter counts down to zero, so a latency of 1 means a single
    // WAIT cycle in which the RAM data is already valid.
    localparam logic [1:0] CNT_INIT = 2'(RD_LAT - 1);

    state_t        state_q, state_d;
    logic [1:0]    cnt_q, cnt_d;
    logic          last_gnt, last_d;
    logic          win1;
    logic [1:0]    gnt_d;
    logic          ram_en_d, ram_we_d;
    logic [AW-1:0] ram_addr_d;
    logic [DW-1:0] ram_wdata_d;
    logic          ack0_d, ack1_d;
    logic [DW-1:0] rdata0_d, rdata1_d;
    logic          busy_d;

    // Every output is a register: the next-state logic below computes the
    // value each output should take in the following cycle.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= 2'd0;
            last_gnt  <= 1'b1;
            gnt       <= 2'b00;
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            rdata0    <= '0;
            rdata1    <= '0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            last_gnt  <= last_d;
            gnt       <= gnt_d;
            ram_en    <= ram_en_d;
            ram_we    <= ram_we_d;
            ram_addr  <= ram_addr_d;
            ram_wdata <= ram_wdata_d;
            ack0      <= ack0_d;
            ack1      <= ack1_d;
            rdata0    <= rdata0_d;
            rdata1    <= rdata1_d;
            busy      <= busy_d;
        end
    end

    // Next-state and next-output logic. The RAM command is latched on the
    // IDLE->ISSUE edge so ram_en is high exactly during ISSUE and the
    // command fields hold their values afterwards.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_d      = last_gnt;
        gnt_d       = gnt;
        ram_en_d    = 1'b0;
        ram_we_d    = ram_we;
        ram_addr_d  = ram_addr;
        ram_wdata_d = ram_wdata;
        ack0_d      = 1'b0;
        ack1_d      = 1'b0;
        rdata0_d    = rdata0;
        rdata1_d    = rdata1;
        win1        = 1'b0;

        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    // On a tie, round-robin hands the grant to the port that
                    // did not win last time.
                    if (req0 && req1) begin
                        win1 = (PRIORITY == 1) ? 1'b0 : ~last_gnt;
                    end else begin
                        win1 = req1;
                    end
                    last_d      = win1;
                    gnt_d       = win1 ? 2'b10 : 2'b01;
                    ram_en_d    = 1'b1;
                    ram_we_d    = win1 ? we1    : we0;
                    ram_addr_d  = win1 ? addr1  : addr0;
                    ram_wdata_d = win1 ? wdata1 : wdata0;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                if (ram_we) begin
                    ack0_d  = gnt[0];
                    ack1_d  = gnt[1];
                    state_d = ACK;
                end else begin
                    cnt_d   = CNT_INIT;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == 2'd0) begin
                    if (gnt[1]) begin
                        rdata1_d = ram_rdata;
                    end else begin
                        rdata0_d = ram_rdata;
                    end
                    ack0_d  = gnt[0];
                    ack1_d  = gnt[1];
                    state_d = ACK;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            ACK: begin
                gnt_d   = 2'b00;
                state_d = IDLE;
            end
            default: begin
                gnt_d   = 2'b00;
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

endmodule

// File: tb/tb_hrm_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_hrm_mem_arbiter
// Drives two arbiter instances sharing clock and reset:
//   instance 0: PRIORITY=0, RD_LAT=1
//   instance 1: PRIORITY=1, RD_LAT=3
// Each instance has its own RAM model whose read data is only valid exactly
// RD_LAT cycles after the issue cycle (X otherwise).
// ---------------------------------------------------------------------------
module tb_hrm_mem_arbiter;

    logic       clk;
    logic       rst_n;
    logic       req   [2][2];
    logic       we    [2][2];
    logic [7:0] addr  [2][2];
    logic [7:0] wdata [2][2];
    logic       ack   [2][2];
    logic [7:0] rdata [2][2];
    logic       ram_en    [2];
    logic       ram_we    [2];
    logic [7:0] ram_addr  [2];
    logic [7:0] ram_wdata [2];
    logic [7:0] ram_rdata [2];
    logic [1:0] gnt       [2];
    logic       busy      [2];

    logic [7:0] mem  [2][256];
    logic [7:0] pipe [2][3];

    typedef struct {
        int         lat;
        bit         is_write;
        logic [7:0] data;
    } exp_t;

    exp_t sb[$];
    int   exp_order[$];
    int   tie_order[4];
    int   tie_got;

    int compared;
    int mismatched;

    hrm_mem_arbiter #(.AW(8), .DW(8), .RD_LAT(1), .PRIORITY(0)) dut0 (
        .clk(clk), .i_rst_n(rst_n),
        .req0(req[0][0]), .we0(we[0][0]), .addr0(addr[0][0]), .wdata0(wdata[0][0]),
        .ack0(ack[0][0]), .rdata0(rdata[0][0]),
        .req1(req[0][1]), .we1(we[0][1]), .addr1(addr[0][1]), .wdata1(wdata[0][1]),
        .ack1(ack[0][1]), .rdata1(rdata[0][1]),
        .ram_en(ram_en[0]), .ram_we(ram_we[0]), .ram_addr(ram_addr[0]),
        .ram_wdata(ram_wdata[0]), .ram_rdata(ram_rdata[0]),
        .gnt(gnt[0]), .busy(busy[0])
    );

    hrm_mem_arbiter #(.AW(8), .DW(8), .RD_LAT(3), .PRIORITY(1)) dut1 (
        .clk(clk), .i_rst_n(rst_n),
        .req0(req[1][0]), .we0(we[1][0]), .addr0(addr[1][0]), .wdata0(wdata[1][0]),
        .ack0(ack[1][0]), .rdata0(rdata[1][0]),
        .req1(req[1][1]), .we1(we[1][1]), .addr1(addr[1][1]), .wdata1(wdata[1][1]),
        .ack1(ack[1][1]), .rdata1(rdata[1][1]),
        .ram_en(ram_en[1]), .ram_we(ram_we[1]), .ram_addr(ram_addr[1]),
        .ram_wdata(ram_wdata[1]), .ram_rdata(ram_rdata[1]),
        .gnt(gnt[1]), .busy(busy[1])
    );

    // 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // RAM models: writes land on the strobe edge; read data walks down a
    // three-stage pipe so it appears only RD_LAT cycles after the issue cycle.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (ram_en[d] === 1'b1) begin
                if (ram_we[d]) begin
                    mem[d][ram_addr[d]] <= ram_wdata[d];
                    pipe[d][0] <= 8'hxx;
                end else begin
                    pipe[d][0] <= mem[d][ram_addr[d]];
                end
            end else begin
                pipe[d][0] <= 8'hxx;
            end
            pipe[d][1] <= pipe[d][0];
            pipe[d][2] <= pipe[d][1];
        end
    end

    // Each instance sees the pipe stage matching its own read latency.
    always_comb begin
        ram_rdata[0] = pipe[0][0];
        ram_rdata[1] = pipe[1][2];
    end

    // Hard stop in case something hangs outside the bounded loops.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Runs one transaction on instance d, port p, starting in an IDLE cycle.
    // Reports latency (-1 on timeout), issue cycle, the latched RAM command,
    // read data at ack, whether gnt stayed on p, and any stray ack on the
    // other port. hold>0 drops req after that many cycles.
    task automatic do_txn(input int d, input int p, input bit w, input logic [7:0] a,
                          input logic [7:0] wd, input int hold,
                          output int lat, output int en_cyc, output logic en_we,
                          output logic [7:0] en_addr, output logic [7:0] en_wdata,
                          output logic [7:0] rd, output bit gnt_ok, output bit other_ack);
        int n;
        lat = -1; en_cyc = -1; en_we = 1'b0; en_addr = '0; en_wdata = '0;
        rd = '0; gnt_ok = 1'b1; other_ack = 1'b0; n = 0;
        @(posedge clk);
        #1;
        we[d][p] = w; addr[d][p] = a; wdata[d][p] = wd; req[d][p] = 1'b1;
        while (n < 20 && lat < 0) begin
            @(posedge clk);
            #1;
            n++;
            if (ram_en[d] === 1'b1 && en_cyc < 0) begin
                en_cyc = n; en_we = ram_we[d]; en_addr = ram_addr[d]; en_wdata = ram_wdata[d];
            end
            if (gnt[d] !== ((p == 1) ? 2'b10 : 2'b01)) gnt_ok = 1'b0;
            if (ack[d][1-p] !== 1'b0) other_ack = 1'b1;
            if (hold > 0 && n >= hold) req[d][p] = 1'b0;
            if (ack[d][p] === 1'b1) begin
                lat = n;
                rd = rdata[d][p];
                req[d][p] = 1'b0;
            end
        end
        req[d][p] = 1'b0;
    endtask

    // Both ports of instance d request together and re-assert in the IDLE
    // cycle after each ack; port 0 stops re-asserting after limit0 grants.
    task automatic tie_run(input int d, input int limit0);
        int  cyc;
        int  served0;
        bit  rearm[2];
        cyc = 0; served0 = 0; tie_got = 0;
        rearm[0] = 1'b0; rearm[1] = 1'b0;
        for (int k = 0; k < 4; k++) tie_order[k] = -1;
        @(posedge clk);
        #1;
        for (int p = 0; p < 2; p++) begin
            we[d][p] = 1'b1; addr[d][p] = 8'h10 + 8'(p); wdata[d][p] = 8'h55; req[d][p] = 1'b1;
        end
        while (tie_got < 4 && cyc < 60) begin
            @(posedge clk);
            #1;
            cyc++;
            for (int p = 0; p < 2; p++) begin
                if (rearm[p]) begin
                    req[d][p] = 1'b1;
                    rearm[p] = 1'b0;
                end
            end
            for (int p = 0; p < 2; p++) begin
                if (ack[d][p] === 1'b1 && tie_got < 4) begin
                    tie_order[tie_got] = p;
                    tie_got++;
                    req[d][p] = 1'b0;
                    if (p == 0) served0++;
                    if (p == 1 || served0 < limit0) rearm[p] = 1'b1;
                end
            end
            if (tie_got >= 4) begin
                req[d][0] = 1'b0; req[d][1] = 1'b0;
            end
        end
        req[d][0] = 1'b0; req[d][1] = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_reset();
        logic [38:0] v;
        do_reset();
        #1;
        for (int d = 0; d < 2; d++) begin
            v = {ack[d][0], ack[d][1], rdata[d][0], rdata[d][1], ram_en[d], ram_we[d],
                 ram_addr[d], ram_wdata[d], gnt[d], busy[d]};
            compared++;
            if (v !== 39'd0) begin
                mismatched++;
                $display("[TB] FAIL reset_outputs dut%0d: actual=%h required=0", d, v);
            end
        end
    endtask

    task automatic test_write();
        int lat, en_cyc; logic en_we; logic [7:0] en_addr, en_wdata, rd; bit gok, oack;
        exp_t e;
        sb.push_back('{lat: 2, is_write: 1'b1, data: 8'h00});
        do_txn(0, 0, 1'b1, 8'h05, 8'h2A, 0, lat, en_cyc, en_we, en_addr, en_wdata, rd, gok, oack);
        e = sb.pop_front();
        compared++;
        if (lat !== e.lat) begin
            mismatched++;
            $display("[TB] FAIL write_ack_latency: actual=%0d required=%0d", lat, e.lat);
        end
        compared++;
        if ({en_cyc == 1, en_we, en_addr, en_wdata} !== {1'b1, 1'b1, 8'h05, 8'h2A}) begin
            mismatched++;
            $display("[TB] FAIL write_ram_cmd: actual cyc=%0d we=%b addr=%h wdata=%h required cyc=1 we=1 addr=05 wdata=2a",
                     en_cyc, en_we, en_addr, en_wdata);
        end
        compared++;
        if (oack !== 1'b0 || gok !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL write_gnt_ack1: actual gnt_ok=%b ack1_seen=%b required gnt_ok=1 ack1_seen=0", gok, oack);
        end
        @(posedge clk);
        #1;
        compared++;
        if ({ack[0][0], busy[0], gnt[0]} !== 4'b0000) begin
            mismatched++;
            $display("[TB] FAIL write_back_to_idle: actual ack0=%b busy=%b gnt=%b required 0/0/00",
                     ack[0][0], busy[0], gnt[0]);
        end
    endtask

    task automatic test_read();
        int lat, en_cyc; logic en_we; logic [7:0] en_addr, en_wdata, rd; bit gok, oack;
        exp_t e;
        sb.push_back('{lat: 3, is_write: 1'b0, data: 8'h2A});
        do_txn(0, 0, 1'b0, 8'h05, 8'h00, 0, lat, en_cyc, en_we, en_addr, en_wdata, rd, gok, oack);
        e = sb.pop_front();
        compared++;
        if (lat !== e.lat || rd !== e.data) begin
            mismatched++;
            $display("[TB] FAIL read_lat1: actual lat=%0d rdata0=%h required lat=%0d rdata0=%h", lat, rd, e.lat, e.data);
        end
        compared++;
        if (rdata[0][1] !== 8'h00 || en_we !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL read_rdata1_untouched: actual rdata1=%h ram_we=%b required rdata1=00 ram_we=0",
                     rdata[0][1], en_we);
        end
    endtask

    task automatic test_back_to_back();
        int lat, en_cyc; logic en_we; logic [7:0] en_addr, en_wdata, rd; bit gok, oack;
        exp_t e;
        // Port 1 drops req right after issue; the write must still complete.
        sb.push_back('{lat: 2, is_write: 1'b1, data: 8'h00});
        do_txn(0, 1, 1'b1, 8'h40, 8'h33, 1, lat, en_cyc, en_we, en_addr, en_wdata, rd, gok, oack);
        e = sb.pop_front();
        compared++;
        if (lat !== e.lat || gok !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL early_drop_write: actual lat=%0d gnt_ok=%b required lat=%0d gnt_ok=1", lat, gok, e.lat);
        end
        sb.push_back('{lat: 3, is_write: 1'b0, data: 8'h33});
        do_txn(0, 0, 1'b0, 8'h40, 8'h00, 0, lat, en_cyc, en_we, en_addr, en_wdata, rd, gok, oack);
        e = sb.pop_front();
        compared++;
        if (lat !== e.lat || rd !== e.data || rdata[0][1] !== 8'h00) begin
            mismatched++;
            $display("[TB] FAIL b2b_read: actual lat=%0d rdata0=%h rdata1=%h required lat=%0d rdata0=%h rdata1=00",
                     lat, rd, rdata[0][1], e.lat, e.data);
        end
    endtask

    task automatic test_read_lat3();
        int lat, en_cyc; logic en_we; logic [7:0] en_addr, en_wdata, rd; bit gok, oack;
        exp_t e;
        sb.push_back('{lat: 2, is_write: 1'b1, data: 8'h00});
        do_txn(1, 1, 1'b1, 8'h1F, 8'h80, 0, lat, en_cyc, en_we, en_addr, en_wdata, rd, gok, oack);
        e = sb.pop_front();
        compared++;
        if (lat !== e.lat) begin
            mismatched++;
            $display("[TB] FAIL lat3_setup_write: actual lat=%0d required lat=%0d", lat, e.lat);
        end
        sb.push_back('{lat: 5, is_write: 1'b0, data: 8'h80});
        do_txn(1, 1, 1'b0, 8'h1F, 8'h00, 0, lat, en_cyc, en_we, en_addr, en_wdata, rd, gok, oack);
        e = sb.pop_front();
        compared++;
        if (lat !== e.lat || rd !== e.data) begin
            mismatched++;
            $display("[TB] FAIL read_lat3: actual lat=%0d rdata1=%h required lat=%0d rdata1=%h", lat, rd, e.lat, e.data);
        end
        compared++;
        if (gok !== 1'b1 || oack !== 1'b0 || en_cyc !== 1 || rdata[1][0] !== 8'h00) begin
            mismatched++;
            $display("[TB] FAIL lat3_gnt_window: actual gnt_ok=%b ack0_seen=%b en_cyc=%0d rdata0=%h required 1/0/1/00",
                     gok, oack, en_cyc, rdata[1][0]);
        end
    endtask

    task automatic test_round_robin();
        int want;
        do_reset();
        exp_order = '{0, 1, 0, 1};
        tie_run(0, 100);
        for (int k = 0; k < 4; k++) begin
            want = exp_order.pop_front();
            compared++;
            if (tie_order[k] !== want) begin
                mismatched++;
                $display("[TB] FAIL round_robin_grant%0d: actual=%0d required=%0d", k, tie_order[k], want);
            end
        end
    endtask

    task automatic test_priority();
        int want;
        do_reset();
        exp_order = '{0, 0, 0, 1};
        tie_run(1, 3);
        for (int k = 0; k < 4; k++) begin
            want = exp_order.pop_front();
            compared++;
            if (tie_order[k] !== want) begin
                mismatched++;
                $display("[TB] FAIL priority_grant%0d: actual=%0d required=%0d", k, tie_order[k], want);
            end
        end
    endtask

    task automatic test_reset_abort();
        bit seen_ack;
        seen_ack = 1'b0;
        @(posedge clk);
        #1;
        we[1][1] = 1'b0; addr[1][1] = 8'h1F; req[1][1] = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        compared++;
        if (busy[1] !== 1'b1 || gnt[1] !== 2'b10) begin
            mismatched++;
            $display("[TB] FAIL abort_in_wait: actual busy=%b gnt=%b required busy=1 gnt=10", busy[1], gnt[1]);
        end
        rst_n = 1'b0;
        #1;
        compared++;
        if ({ram_en[1], gnt[1], busy[1], ack[1][0], ack[1][1]} !== 6'b000000) begin
            mismatched++;
            $display("[TB] FAIL abort_async_clear: actual en=%b gnt=%b busy=%b ack0=%b ack1=%b required all 0",
                     ram_en[1], gnt[1], busy[1], ack[1][0], ack[1][1]);
        end
        req[1][1] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 8; n++) begin
            @(posedge clk);
            #1;
            if (ack[1][0] !== 1'b0 || ack[1][1] !== 1'b0) seen_ack = 1'b1;
        end
        compared++;
        if (seen_ack !== 1'b0 || busy[1] !== 1'b0 || gnt[1] !== 2'b00) begin
            mismatched++;
            $display("[TB] FAIL abort_no_ack: actual ack_seen=%b busy=%b gnt=%b required 0/0/00",
                     seen_ack, busy[1], gnt[1]);
        end
    endtask

    // Test sequence.
    initial begin
        compared = 0;
        mismatched = 0;
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < 2; p++) begin
                req[d][p] = 1'b0; we[d][p] = 1'b0; addr[d][p] = '0; wdata[d][p] = '0;
            end
        end
        $display("[TB] starting hrm_mem_arbiter bench");
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_read_lat3();
        test_round_robin();
        test_priority();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
